uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_buf.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_buf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buf.sv
// UART receiver with a first-word-fall-through receive FIFO, parity/framing checks and sticky overrun.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote around the nominal sample clock.
module uart_rx_buf #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop_bits,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 r_sync1, r_sync2, r_rx_d1, r_rx_d2;
    logic                 w_sample, w_fall, w_low_any;

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [BIT_W-1:0]     r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_par_en, w_par_en_next;
    logic                 r_par_odd, w_par_odd_next;
    logic                 r_stop2, w_stop2_next;
    logic                 r_stop_idx, w_stop_idx_next;
    logic                 r_stop_low, w_stop_low_next;
    logic                 r_par_bad, w_par_bad_next;
    logic                 r_wr, w_wr_next;
    logic                 r_perr, w_perr_next;
    logic                 r_ferr, w_ferr_next;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 r_overrun;
    logic                 w_empty, w_full, w_pop, w_push, w_ovf;

    // r_rx_d1 is the sampling point so the vote can see one clock either side of it
    // with the same latency in both builds.
`ifdef UART_RX_MAJORITY_EN
    assign w_sample = (r_rx_d2 & r_rx_d1) | (r_rx_d2 & r_sync2) | (r_rx_d1 & r_sync2);
`else
    assign w_sample = r_rx_d1;
`endif
    assign w_fall    = r_rx_d2 & ~r_rx_d1;
    assign w_low_any = r_stop_low | ~w_sample;

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + 1'b1;
        w_bit_next      = r_bit;
        w_shift_next    = r_shift;
        w_par_en_next   = r_par_en;
        w_par_odd_next  = r_par_odd;
        w_stop2_next    = r_stop2;
        w_stop_idx_next = r_stop_idx;
        w_stop_low_next = r_stop_low;
        w_par_bad_next  = r_par_bad;
        w_wr_next       = 1'b0;
        w_perr_next     = 1'b0;
        w_ferr_next     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_fall) begin
                    w_state_next    = START;
                    w_par_en_next   = parity_en;
                    w_par_odd_next  = parity_odd;
                    w_stop2_next    = stop_bits;
                    w_bit_next      = '0;
                    w_stop_idx_next = 1'b0;
                    w_stop_low_next = 1'b0;
                    w_par_bad_next  = 1'b0;
                end
            end
            START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = w_sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_sample, r_shift[DATA_BITS-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next     = '0;
                    w_par_bad_next = ((^r_shift) ^ w_sample) != r_par_odd;
                    w_state_next   = STOP;
                end
            end
            STOP: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_next      = '0;
                    w_stop_low_next = w_low_any;
                    if (r_stop2 && !r_stop_idx) begin
                        w_stop_idx_next = 1'b1;
                    end else begin
                        // A low stop sample outranks a parity error.
                        w_state_next = IDLE;
                        w_ferr_next  = w_low_any;
                        w_perr_next  = ~w_low_any & r_par_bad;
                        w_wr_next    = ~w_low_any & ~r_par_bad;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_d1    <= 1'b1;
            r_rx_d2    <= 1'b1;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_stop_low <= 1'b0;
            r_par_bad  <= 1'b0;
            r_wr       <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync1    <= rx;
            r_sync2    <= r_sync1;
            r_rx_d1    <= r_sync2;
            r_rx_d2    <= r_rx_d1;
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_par_en   <= w_par_en_next;
            r_par_odd  <= w_par_odd_next;
            r_stop2    <= w_stop2_next;
            r_stop_idx <= w_stop_idx_next;
            r_stop_low <= w_stop_low_next;
            r_par_bad  <= w_par_bad_next;
            r_wr       <= w_wr_next;
            r_perr     <= w_perr_next;
            r_ferr     <= w_ferr_next;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);
    assign w_pop   = rd_en & ~w_empty;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign w_push  = r_wr & (~w_full | w_pop);
    assign w_ovf   = r_wr & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data    = r_mem[r_rd_ptr];
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Bench for uart_rx_buf at default parameters: directed cases plus random frames against a queue model.
module tb_uart_rx_buf;

    localparam int DIV   = 217;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    // Two synchroniser flops plus one register ahead of the sampling point.
    localparam int SYNC_LAT = 3;
    // Clock (counted from the start-bit drive) of the stop sample for an 8N1 frame.
    localparam int STOP_SAMPLE_8N1 = SYNC_LAT + DIV / 2 + (1 + DB) * DIV;

    logic       clk = 1'b0;
    logic       rst, rx, parity_en, parity_odd, stop_bits, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [4:0] count;
    logic       parity_err, frame_err, overrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         exp_perr = 0;
    int         exp_ferr = 0;
    logic [7:0] q[$];
    bit         m_ovr = 1'b0;

    uart_rx_buf dut (
        .clk(clk), .rst(rst), .rx(rx), .parity_en(parity_en), .parity_odd(parity_odd),
        .stop_bits(stop_bits), .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit s2,
                              input bit bad_par, input bit bad_stop, input int glitch_bit);
        parity_en  = pen;
        parity_odd = podd;
        stop_bits  = s2;
        rx = 1'b0;
        cyc(DIV);
        // Settings are latched at frame start; disturbing them now must not matter.
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        stop_bits  = 1'($urandom);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            if (i == glitch_bit) begin
                cyc(DIV / 2);
                rx = ~d[i];
                cyc(1);
                rx = d[i];
                cyc(DIV - DIV / 2 - 1);
            end else begin
                cyc(DIV);
            end
        end
        if (pen) begin
            rx = (^d) ^ podd ^ bad_par;
            cyc(DIV);
        end
        rx = ~bad_stop;
        cyc(DIV);
        if (s2) begin
            rx = 1'b1;
            cyc(DIV);
        end
        rx = 1'b1;
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit pen, input bit bad_par, input bit bad_stop);
        if (bad_stop) exp_ferr++;
        else if (pen && bad_par) exp_perr++;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(d);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
        check({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        if (q.size() > 0) check({tag, "_head"}, 32'(rd_data), 32'(q[0]));
    endtask

    task automatic pop_check(input string tag);
        check(tag, 32'(rd_data), 32'(q[0]));
        void'(q.pop_front());
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] ov [17];
        bit pen, podd, s2, bp, bs;
        int inj;

        rst = 1'b1; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; stop_bits = 1'b0;
        rd_en = 1'b0; clr_err = 1'b0;
        cyc(3);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        cyc(10);

        // 8N1 0x36: occupancy appears exactly two clocks after the stop sample.
        fork
            send_frame(8'h36, 0, 0, 0, 0, 0, -1);
            begin
                cyc(STOP_SAMPLE_8N1 + 1);
                check("lat_before_count", 32'(count), 32'd0);
                cyc(1);
                check("lat_count", 32'(count), 32'd1);
                check("lat_empty", 32'(empty), 32'd0);
                check("lat_data", 32'(rd_data), 32'h36);
            end
        join
        expect_frame(8'h36, 0, 0, 0);
        cyc(5);
        check_state("b36");
        pop_check("b36_pop");
        check_state("b36_after_pop");

        // Even parity, 0x32 with parity bit 0 is wrong.
        send_frame(8'h32, 1, 0, 0, 1, 0, -1);
        expect_frame(8'h32, 1, 1, 0);
        cyc(5);
        check_state("par");

        // Low stop bit on 0x38, then 0x34 clean.
        send_frame(8'h38, 0, 0, 0, 0, 1, -1);
        expect_frame(8'h38, 0, 0, 1);
        cyc(20);
        check_state("frm");
        send_frame(8'h34, 0, 0, 0, 0, 0, -1);
        expect_frame(8'h34, 0, 0, 0);
        cyc(5);
        check_state("frm_next");
        pop_check("frm_next_pop");

        // 100-clock low glitch is a false start.
        rx = 1'b0;
        cyc(100);
        rx = 1'b1;
        cyc(2 * DIV);
        check_state("glitch");

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h5A, 0, 0, 0, 0, 0, 3);
        expect_frame(8'h5A, 0, 0, 0);
        cyc(5);
        check_state("maj");
        pop_check("maj_pop");
`endif

        // Random frames with random framing and injected errors.
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            s2   = 1'($urandom);
            inj  = $urandom_range(0, 3);
            bp   = (inj == 2);
            bs   = (inj == 3);
            send_frame(d, pen, podd, s2, bp, bs, -1);
            expect_frame(d, pen, bp, bs);
            cyc($urandom_range(2, 20));
            check_state("rand");
            if ($urandom_range(0, 2) == 0 && q.size() > 0) pop_check("rand_pop");
        end
        while (q.size() > 0) pop_check("drain");
        check_state("drained");

        // 17 back-to-back frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) ov[i] = 8'($urandom);
        for (int i = 0; i < 17; i++) begin
            send_frame(ov[i], 0, 0, 0, 0, 0, -1);
            expect_frame(ov[i], 0, 0, 0);
        end
        cyc(3);
        check_state("ovr");
        check("ovr_head_frame1", 32'(rd_data), 32'(ov[0]));
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        m_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Write and pop in the same cycle while full.
        d = 8'($urandom);
        fork
            send_frame(d, 0, 0, 0, 0, 0, -1);
            begin
                cyc(STOP_SAMPLE_8N1 + 1);
                check("full_rw_head", 32'(rd_data), 32'(q[0]));
                void'(q.pop_front());
                rd_en = 1'b1;
                cyc(1);
                rd_en = 1'b0;
            end
        join
        q.push_back(d);
        cyc(3);
        check_state("full_rw");

        // Reset during data bit 3 of 0x37 with a full FIFO.
        d = 8'h37;
        parity_en = 1'b0; stop_bits = 1'b0;
        rx = 1'b0;
        cyc(DIV);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            cyc(DIV);
        end
        rx = d[3];
        cyc(50);
        rst = 1'b1;
        rx = 1'b1;
        cyc(1);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ovr", 32'(overrun), 32'd0);
        check("mid_rst_perr", 32'(parity_err), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        q.delete();
        cyc(3 * DIV);
        check_state("post_rst");
        send_frame(8'hA5, 0, 0, 0, 0, 0, -1);
        expect_frame(8'hA5, 0, 0, 0);
        cyc(5);
        check_state("a5");
        pop_check("a5_pop");
        check_state("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
